int_controller: RTL
===================

INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 SHALL have parameter IF_RESET, default 5'h00, giving the IF[4:0] value loaded on reset.
REQ-002 SHALL have parameter IE_RESET, default 8'h00, giving the IE[7:0] value loaded on reset.
REQ-003 SHALL have port i_Clk  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Rst  in  1  asynchronous reset, active-high.
REQ-005 SHALL have port i_Enable  in  1  register access strobe, driven by the last-page decoder's interrupt-controller enable.
REQ-006 SHALL have port i_Address  in  1  register select: 1 = IF (FF0F), 0 = IE (FFFF).
REQ-007 SHALL have port i_Write  in  1  write qualifier, sampled with i_Enable.
REQ-008 SHALL have port i_Data  in  8  write data.
REQ-009 SHALL have port o_Data  out  8  read data of the selected register.
REQ-010 SHALL have port i_Request  in  5  one-cycle request pulses, bit order [0] VBlank, [1] STAT, [2] Timer, [3] Serial, [4] Joypad.
REQ-011 SHALL have ports i_EI, i_DI, i_RETI  in  1 each  CPU IME-control strobes.
REQ-012 SHALL have port i_Instr_Boundary  in  1  one-cycle pulse marking an instruction boundary.
REQ-013 SHALL have port i_Int_Ack  in  1  CPU accepts the dispatch.
REQ-014 SHALL have port o_Int_Req  out  1  dispatch request to the CPU.
REQ-015 SHALL have port o_Vector  out  8  dispatch vector.
REQ-016 SHALL have port o_Wake  out  1  HALT exit indication.

Function
REQ-017 SHALL hold IF[4:0]; set bit k on the edge after i_Request[k]=1.
REQ-018 SHALL write IF <= i_Data[4:0] on i_Enable & i_Write & i_Address; write IE <= i_Data on i_Enable & i_Write & ~i_Address.
REQ-019 SHALL resolve a request and a CPU IF write in the same cycle as IF <= i_Data[4:0] | i_Request.
REQ-020 SHALL drive o_Data combinationally as {3'b111, IF} when i_Address=1 and IE when i_Address=0, independent of i_Enable.
REQ-021 SHALL define pending = IF & IE[4:0]; drive o_Wake = |pending regardless of IME.
REQ-022 SHALL hold an IME flag plus an ei_armed flag.
REQ-023 SHALL apply IME-control strobes as follows:
- i_EI sets ei_armed.
- The next i_Instr_Boundary strictly after the i_EI cycle sets IME and clears ei_armed.
- i_DI clears IME and ei_armed immediately.
- i_RETI sets IME immediately.
- DI wins over EI/RETI in the same cycle.
REQ-024 SHALL implement FSM states IDLE, DISPATCH, SERVICE.
REQ-025 IDLE -> DISPATCH SHALL occur on an edge where IME=1, |pending=1 and i_Instr_Boundary=1.
REQ-026 SHALL behave in DISPATCH as follows:
- o_Int_Req=1.
- o_Vector tracks the highest-priority (lowest index) pending bit k as 8'h40 + 8*k.
- If pending becomes 0 before the ack, o_Vector is 8'h00.
REQ-027 SHALL, on i_Int_Ack in DISPATCH:
- latch o_Vector;
- clear IF bit k (no clear if the vector is 8'h00);
- clear IME and ei_armed;
- go to SERVICE.
REQ-028 SHALL, if i_Request[k] coincides with the ack clearing bit k, leave bit k set (request wins).
REQ-029 SHALL, if an i_DI strobe occurs in DISPATCH before the ack, return the FSM to IDLE and drop o_Int_Req on the next edge.
REQ-030 SHALL, in SERVICE, hold o_Int_Req=0 and o_Vector latched; go SERVICE -> IDLE on the next i_Instr_Boundary.
REQ-031 SHALL ignore i_Int_Ack outside DISPATCH.
REQ-032 SHALL drive o_Vector=8'h00 in IDLE.

Reset
REQ-033 SHALL, while i_Rst=1, asynchronously force: IF=IF_RESET, IE=IE_RESET, IME=0, ei_armed=0, FSM=IDLE, o_Int_Req=0, o_Vector=8'h00.
REQ-034 SHALL, on reset mid-DISPATCH or mid-SERVICE, abandon the dispatch with no IF bit cleared beyond the IF_RESET value.
REQ-035 SHALL resume normal operation on the first rising edge after i_Rst deasserts.

Verification
REQ-036 The bench SHALL cover: IE=8'h1F, EI strobe then 2 boundaries, i_Request=5'b00100 -> DISPATCH, o_Vector=8'h50; ack -> IF=5'h00, IME=0.
REQ-037 The bench SHALL cover: IF=5'b10010 via write, IE=8'hFF, IME=1, boundary -> o_Vector=8'h48; ack -> IF=5'b10000.
REQ-038 The bench SHALL cover: in DISPATCH, write IE=8'h00 before the ack -> o_Vector=8'h00; ack -> IF unchanged, IME=0.
REQ-039 The bench SHALL cover: ack for bit 0 coinciding with i_Request[0] pulse -> IF[0]=1 afterwards.
REQ-040 The bench SHALL cover: IME=0, IE=8'h01, i_Request[0] -> o_Wake=1, o_Int_Req stays 0; read FF0F -> o_Data=8'hE1.
REQ-041 The bench SHALL cover: i_Rst asserted mid-DISPATCH without a clock edge -> o_Int_Req=0, IF=IF_RESET immediately.

Source files
------------

// File: rtl/int_controller.sv
`default_nettype none
// ============================================================================
// int_controller -- five-source interrupt controller with IF/IE registers,
// IME/EI-delay handling and an IDLE/DISPATCH/SERVICE dispatch handshake.
// Revision: 1.0
// ============================================================================
module int_controller #(
  parameter logic [4:0] IF_RESET = 5'h00,
  parameter logic [7:0] IE_RESET = 8'h00
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  input  logic       i_Address,
  input  logic       i_Write,
  input  logic [7:0] i_Data,
  output logic [7:0] o_Data,
  input  logic [4:0] i_Request,
  input  logic       i_EI,
  input  logic       i_DI,
  input  logic       i_RETI,
  input  logic       i_Instr_Boundary,
  input  logic       i_Int_Ack,
  output logic       o_Int_Req,
  output logic [7:0] o_Vector,
  output logic       o_Wake
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    SERVICE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  if_reg;
  logic [7:0]  ie_reg;
  logic        ime;
  logic        ei_armed;
  logic [7:0]  vec_latched;

  logic [4:0]  pending;
  logic        any_pending;
  logic [2:0]  win_idx;
  logic [4:0]  win_mask;
  logic [7:0]  live_vec;
  logic        write_if;
  logic        write_ie;
  logic        ack_fire;
  logic        ei_fire;
  logic [4:0]  if_next;

  assign pending     = if_reg & ie_reg[4:0];
  assign any_pending = |pending;
  assign o_Wake      = any_pending;
  assign write_if    = i_Enable & i_Write & i_Address;
  assign write_ie    = i_Enable & i_Write & ~i_Address;
  assign o_Data      = i_Address ? {3'b111, if_reg} : ie_reg;

  // Lowest index wins; the vector collapses to 8'h00 when nothing is pending.
  always_comb begin
    win_idx  = 3'd0;
    win_mask = 5'b00000;
    for (int k = 4; k >= 0; k--) begin
      if (pending[k]) begin
        win_idx  = 3'(k);
        win_mask = 5'b00001 << k;
      end
    end
  end

  assign live_vec = any_pending ? (8'h40 + {2'b00, win_idx, 3'b000}) : 8'h00;

  // DI in the ack cycle aborts the dispatch rather than completing it.
  assign ack_fire = (state == DISPATCH) & i_Int_Ack & ~i_DI;
  assign ei_fire  = ei_armed & i_Instr_Boundary;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_Int_Req  = 1'b0;
    o_Vector   = 8'h00;
    case (state)
      IDLE: begin
        if (ime && any_pending && i_Instr_Boundary) begin
          state_next = DISPATCH;
        end
      end
      DISPATCH: begin
        o_Int_Req = 1'b1;
        o_Vector  = live_vec;
        if (i_DI) begin
          state_next = IDLE;
        end else if (i_Int_Ack) begin
          state_next = SERVICE;
        end
      end
      SERVICE: begin
        o_Vector = vec_latched;
        if (i_Instr_Boundary) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request pulses are OR-ed in last so they survive both a CPU write and an ack clear.
  always_comb begin
    if_next = write_if ? i_Data[4:0] : if_reg;
    if (ack_fire) begin
      if_next = if_next & ~win_mask;
    end
    if_next = if_next | i_Request;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      if_reg      <= IF_RESET;
      ie_reg      <= IE_RESET;
      ime         <= 1'b0;
      ei_armed    <= 1'b0;
      vec_latched <= 8'h00;
    end else begin
      if_reg <= if_next;
      if (write_ie) begin
        ie_reg <= i_Data;
      end
      if (ack_fire) begin
        vec_latched <= live_vec;
      end

      if (i_DI || ack_fire) begin
        ime <= 1'b0;
      end else if (i_RETI || ei_fire) begin
        ime <= 1'b1;
      end

      if (i_DI || ack_fire) begin
        ei_armed <= 1'b0;
      end else if (i_EI) begin
        ei_armed <= 1'b1;
      end else if (ei_fire) begin
        ei_armed <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
